// File: rtl/serial_subtractor_4bits.sv
// Bit-serial N-bit subtractor: D = A - B - Bin (mod 2^N) with borrow-out.
// One full-subtractor cell is reused LSB first over N cycles behind a start/busy/done handshake.
module serial_subtractor_4bits #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bout,
  output logic [1:0]   state_dbg_o
);

  localparam int CW = $clog2(N) + 1;

  // Handshake: start is sampled only in IDLE; the accepting edge captures a/b/bin.
  // busy is high for exactly N cycles after that edge, then done pulses for one
  // cycle with d/bout already valid. start seen in SHIFT or DONE is dropped.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  ra_q, ra_d;
  logic [N-1:0]  rb_q, rb_d;
  logic [N-1:0]  rr_q, rr_d;
  logic          borrow_q, borrow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  d_q, d_d;
  logic          bout_q, bout_d;

  logic diff;
  logic borrow_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      rr_q     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rr_q     <= rr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rr_d      = rr_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    d_d       = d_q;
    bout_d    = bout_q;
    diff      = ra_q[0] ^ rb_q[0] ^ borrow_q;
    borrow_nx = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & borrow_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d     = a;
          rb_d     = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        ra_d     = ra_q >> 1;
        rb_d     = rb_q >> 1;
        rr_d     = {diff, rr_q[N-1:1]};
        borrow_d = borrow_nx;
        cnt_d    = cnt_q + CW'(1);
        // Results are published only here, so d/bout never show partial sums.
        if (cnt_q == CW'(N - 1)) begin
          d_d     = {diff, rr_q[N-1:1]};
          bout_d  = borrow_nx;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q == SHIFT);
  assign done        = (state_q == DONE);
  assign d           = d_q;
  assign bout        = bout_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_serial_subtractor_4bits.sv
// Directed bench for serial_subtractor_4bits (N=4): handshake timing, borrow
// cases, ignored start, mid-operation reset, back-to-back and all 512 operands.
module tb_serial_subtractor_4bits;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [3:0] d;
  logic       bout;
  logic [1:0] state_dbg;

  int tests_run;
  int tests_failed;

  serial_subtractor_4bits #(.N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .d          (d),
    .bout       (bout),
    .state_dbg_o(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Runs one operation from IDLE to done; lat counts busy cycles before done.
  task automatic run_op(input logic [3:0] ai, input logic [3:0] bi, input logic bini,
                        output logic [3:0] gd, output logic gb, output int lat,
                        output logic timed_out);
    logic got;
    @(negedge clk);
    a = ai; b = bi; bin = bini; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    bin = 1'($urandom_range(0, 1));
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (busy) lat++;
    end
    gd = d;
    gb = bout;
    timed_out = !got;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, d, bout, state_dbg} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b done=%b d=%0d bout=%b st=%0d, want all 0",
               busy, done, d, bout, state_dbg);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [3:0] gd; logic gb; int lat; logic to;
    run_op(4'd9, 4'd5, 1'b0, gd, gb, lat, to);
    tests_run++;
    if (to !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_timeout: no done within bound");
    end
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL basic_busy_cycles: got %0d, want 4", lat);
    end
    tests_run++;
    if ({gb, gd} !== {1'b0, 4'd4}) begin
      tests_failed++;
      $display("FAIL basic_result: got bout=%b d=%0d, want bout=0 d=4", gb, gd);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_busy_with_done: got busy=%b during done, want 0", busy);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_width: got done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_underflow();
    logic [3:0] va [3] = '{4'd3, 4'd0, 4'd15};
    logic [3:0] vb [3] = '{4'd5, 4'd0, 4'd15};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [4:0] ve [3] = '{5'b1_1110, 5'b1_1111, 5'b1_1111};
    logic [3:0] gd; logic gb; int lat; logic to;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], gd, gb, lat, to);
      tests_run++;
      if (to || {gb, gd} !== ve[i]) begin
        tests_failed++;
        $display("FAIL underflow_%0d: a=%0d b=%0d bin=%b got {bout,d}=%b timeout=%b, want %b",
                 i, va[i], vb[i], vc[i], {gb, gd}, to, ve[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int dones;
    int done_at;
    dones = 0;
    done_at = -1;
    @(negedge clk);
    a = 4'd9; b = 4'd5; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        done_at = i;
      end
      if (i == 1 || done) begin
        start = 1'b1; a = 4'd1; b = 4'd2;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    tests_run++;
    if (dones !== 1 || done_at !== 4) begin
      tests_failed++;
      $display("FAIL ignored_start_pulses: got %0d done(s) last at cycle %0d, want 1 at cycle 4",
               dones, done_at);
    end
    tests_run++;
    if ({bout, d} !== {1'b0, 4'd4} || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignored_start_result: got bout=%b d=%0d busy=%b, want 0 4 0", bout, d, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] gd; logic gb; int lat; logic to;
    int dones;
    @(negedge clk);
    a = 4'd12; b = 4'd3; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, d, bout} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_op: got busy=%b done=%b d=%0d bout=%b, want all 0",
               busy, done, d, bout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_done: got %0d busy/done cycles after release, want 0", dones);
    end
    run_op(4'd12, 4'd3, 1'b0, gd, gb, lat, to);
    tests_run++;
    if (to || {gb, gd} !== {1'b0, 4'd9}) begin
      tests_failed++;
      $display("FAIL reset_fresh_op: got bout=%b d=%0d timeout=%b, want bout=0 d=9", gb, gd, to);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va [3] = '{4'd9, 4'd7, 4'd15};
    logic [3:0] vb [3] = '{4'd5, 4'd10, 4'd0};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [4:0] ve [3] = '{5'b0_0100, 5'b1_1100, 5'b0_1110};
    int j;
    int last_done;
    logic prev_done;
    j = 0;
    last_done = -1;
    prev_done = 1'b0;
    @(negedge clk);
    a = va[0]; b = vb[0]; bin = vc[0]; start = 1'b1;
    for (int cyc = 0; cyc < 40 && j < 3; cyc++) begin
      @(negedge clk);
      tests_run++;
      if (busy && done) begin
        tests_failed++;
        $display("FAIL b2b_overlap: busy and done both high at cycle %0d", cyc);
      end
      if (done) begin
        tests_run++;
        if ({bout, d} !== ve[j]) begin
          tests_failed++;
          $display("FAIL b2b_result_%0d: got {bout,d}=%b, want %b", j, {bout, d}, ve[j]);
        end
        if (j > 0) begin
          tests_run++;
          if (cyc - last_done !== 6) begin
            tests_failed++;
            $display("FAIL b2b_spacing_%0d: got %0d cycles, want 6", j, cyc - last_done);
          end
        end
        last_done = cyc;
        j++;
        prev_done = 1'b1;
      end else if (prev_done) begin
        prev_done = 1'b0;
        if (j < 3) begin
          a = va[j]; b = vb[j]; bin = vc[j];
        end
      end else if (busy) begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        bin = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    tests_run++;
    if (j !== 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d completions, want 3", j);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_exhaustive();
    logic [3:0] gd; logic gb; int lat; logic to;
    logic [4:0] exp_v;
    int bad;
    bad = 0;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          run_op(4'(ai), 4'(bi), 1'(ci), gd, gb, lat, to);
          exp_v = 5'((ai - bi - ci) & 31);
          tests_run++;
          if (to || {gb, gd} !== exp_v || lat !== 4) begin
            tests_failed++;
            bad++;
            $display("FAIL exhaustive: a=%0d b=%0d bin=%0d got {bout,d}=%0d lat=%0d timeout=%b, want %0d lat=4",
                     ai, bi, ci, {gb, gd}, lat, to, exp_v);
          end
        end
      end
    end
    $display("[TB] exhaustive sweep: %0d of 512 combinations wrong", bad);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_underflow();
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_4bits.md
Name: serial_subtractor_4bits

Overview:
- Bit-serial N-bit subtractor with borrow-in. Computes D = A − B − Bin (mod 2^N) and the borrow-out Bout.
- A single 1-bit full-subtractor cell is reused over N clock cycles, LSB first.
- Operands are captured with a start/busy/done handshake.
- Sits in the arithmetic block library as the sequential, inverse-operation counterpart of the combinational ripple full adder. Area-cheap alternative for control datapaths where latency is not critical.

Parameters:
- N, 4, operand and result width in bits (≥2). Counter width = clog2(N)+1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  N  minuend, captured at the accepting edge
- b  input  N  subtrahend, captured at the accepting edge
- bin  input  1  borrow-in, captured at the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when d/bout become valid
- d  output  N  difference, registered
- bout  output  1  borrow-out, registered

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, immediate, independent of clk):
  - state=IDLE; busy=0, done=0, d=0, bout=0.
  - Internal shift registers, borrow flop and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at edge k: load ra←a, rb←b, borrow←bin, cnt←0, state←SHIFT.
  - If start=0: remain in IDLE; outputs hold.
- SHIFT, edges k+1 … k+N, one bit per edge:
  - diff = ra[0]^rb[0]^borrow.
  - borrow_next = (~ra[0]&rb[0]) | (~(ra[0]^rb[0])&borrow).
  - ra, rb shift right. diff shifts into the MSB of the internal result register rr. cnt increments.
  - At the edge processing bit N−1 (edge k+N): d←final rr, bout←borrow_next, state←DONE.
- DONE: done=1 for exactly one cycle; next edge state←IDLE.
- busy = (state==SHIFT). It is high for exactly N cycles, starting the cycle after the accepting edge.
- Latency: done is high in the cycle following edge k+N. The result is valid in that same cycle.
- Back-to-back throughput: one operation per N+2 cycles. The next accept is possible at edge k+N+2.
- d/bout are updated only at completion and hold their value until the next completion or reset. They never show partial results.
- start in SHIFT or DONE is ignored: no restart, no queueing, no operand corruption. a/b/bin may change freely after the accepting edge.
- Arithmetic:
  - {bout,d} equals the (N+1)-bit two's-complement value of a − b − bin.
  - bout=1 iff a < b+bin (unsigned).
- Reset asserted mid-SHIFT: operation aborted, everything returns to reset values, no done pulse. After release, the block waits in IDLE for a fresh start.
- start held high continuously: a new operation is accepted at each IDLE edge. Operands are sampled only at those edges.
- done and busy are never high simultaneously.

Test Plan:
- Basic: a=9, b=5, bin=0, start pulse at edge k → busy high for 4 cycles, done one cycle after edge k+4 with d=4, bout=0.
- Underflow: a=3, b=5, bin=0 → d=14 (0xE), bout=1. Then a=0, b=0, bin=1 → d=15, bout=1. Then a=15, b=15, bin=1 → d=15, bout=1.
- Ignored start: start a=9, b=5. Pulse start with a=1, b=2 during SHIFT and again during DONE → result d=4, bout=0, exactly one done pulse. d stays 4 until the next accepted operation completes.
- Reset mid-op: start a=12, b=3. Assert rst_n=0 after 2 SHIFT cycles (between edges) → d=0, bout=0, busy=0 immediately, no done. After release, a fresh a=12, b=3 gives d=9, bout=0.
- Back-to-back with start held high: operations are accepted every 6 cycles (N=4). Each done is followed by a correct result. Input operands changed while busy do not affect the result in flight.
- Exhaustive self-check: all 512 combinations of a, b (0..15) and bin (0..1), each run to done.
  - Compare {bout,d} against (a − b − bin) mod 32 computed in integer arithmetic.
  - Report every mismatch with operands and got/expected values; final pass/fail message.
